// File: rtl/mat_mult_sequencer_if.sv
// ============================================================================
// Module      : mat_mult_sequencer_if
// Description : Byte-stream and multiplier-side signal bundle for the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mat_mult_sequencer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_load;
  logic [31:0] mult_res;

  modport slave (
    input  in_data, in_valid, out_ready, mult_res,
    output in_ready, out_data, out_valid, mult_a, mult_b, mult_load
  );

  modport master (
    output in_data, in_valid, out_ready, mult_res,
    input  in_ready, out_data, out_valid, mult_a, mult_b, mult_load
  );
endinterface

`default_nettype wire

// File: rtl/mat_mult_sequencer.sv
// ============================================================================
// Module      : mat_mult_sequencer
// Description : Collects two packed 2x2 byte operands, drives an external
//               multiplier, waits MULT_LATENCY cycles and streams the result.
//               Optional macro MAT_MULT_SEQUENCER_CSUM_EN appends an XOR byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_mult_sequencer #(
  parameter int MULT_LATENCY = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  mat_mult_sequencer_if.slave         bus,
  output logic                        busy_o
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;

  localparam logic [7:0] LAT_LAST  = 8'(MULT_LATENCY - 1);
`ifdef MAT_MULT_SEQUENCER_CSUM_EN
  localparam logic [2:0] SEND_LAST = 3'd4;
`else
  localparam logic [2:0] SEND_LAST = 3'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  lat_cnt_q, lat_cnt_d;
  logic [2:0]  send_cnt_q, send_cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        mult_load;
  logic        busy;
  logic [7:0]  send_byte;

`ifdef MAT_MULT_SEQUENCER_CSUM_EN
  logic [7:0]  csum;
  assign csum = res_q[31:24] ^ res_q[23:16] ^ res_q[15:8] ^ res_q[7:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      byte_cnt_q <= 3'd0;
      lat_cnt_q  <= 8'd0;
      send_cnt_q <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      res_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      send_cnt_q <= send_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    send_cnt_d = send_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    case (state_q)
      S_COLLECT: begin
        // Shifting in from the LSB leaves byte 0 in the top lane after four beats
        if (bus.in_valid) begin
          if (!byte_cnt_q[2]) a_d = {a_q[23:0], bus.in_data};
          else                b_d = {b_q[23:0], bus.in_data};
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        lat_cnt_d = 8'd0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          res_d      = bus.mult_res;
          lat_cnt_d  = 8'd0;
          send_cnt_d = 3'd0;
          state_d    = S_SEND;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (send_cnt_q == SEND_LAST) begin
            send_cnt_d = 3'd0;
            state_d    = S_COLLECT;
          end else begin
            send_cnt_d = send_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_COLLECT);
    busy      = (state_q != S_COLLECT);
    out_valid = (state_q == S_SEND);
    mult_load = (state_q == S_LOAD);
    send_byte = 8'h00;
    case (send_cnt_q)
      3'd0:    send_byte = res_q[31:24];
      3'd1:    send_byte = res_q[23:16];
      3'd2:    send_byte = res_q[15:8];
      3'd3:    send_byte = res_q[7:0];
`ifdef MAT_MULT_SEQUENCER_CSUM_EN
      3'd4:    send_byte = csum;
`endif
      default: send_byte = 8'h00;
    endcase
    out_data = out_valid ? send_byte : 8'h00;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.mult_load = mult_load;
  assign bus.mult_a    = a_q;
  assign bus.mult_b    = b_q;
  assign busy_o        = busy;

endmodule

`default_nettype wire

// File: tb/tb_mat_mult_sequencer.sv
// ============================================================================
// Module      : tb_mat_mult_sequencer
// Description : Randomized self-checking bench for mat_mult_sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_mult_sequencer;
  localparam int L = 9;
`ifdef MAT_MULT_SEQUENCER_CSUM_EN
  localparam int NOUT = 5;
`else
  localparam int NOUT = 4;
`endif
  localparam int BOUND = 3000;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  always #5 clk = ~clk;

  mat_mult_sequencer_if bus();

  mat_mult_sequencer #(.MULT_LATENCY(L)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy_o (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int ready_mode = 0;
  int load_cnt = 0;
  int last_rx_cyc = 0;
  int first_valid_cyc = 0;
  int acc0_cyc = 0;
  int acc7_cyc = 0;

  // 2x2 matrix product with byte wrap, row-major packing {x00,x01,x10,x11}
  function automatic logic [31:0] ref_mm(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ma[2][2];
    logic [7:0] mb[2][2];
    logic [7:0] r[2][2];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = a[31-8*(2*i+j) -: 8];
        mb[i][j] = b[31-8*(2*i+j) -: 8];
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[i][j] = 8'(ma[i][0] * mb[0][j] + ma[i][1] * mb[1][j]);
    return {r[0][0], r[0][1], r[1][0], r[1][1]};
  endfunction

  task automatic push_exp(input logic [7:0] f[8]);
    logic [31:0] r;
    r = ref_mm({f[0], f[1], f[2], f[3]}, {f[4], f[5], f[6], f[7]});
    exp_q.push_back(r[31:24]);
    exp_q.push_back(r[23:16]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
    if (NOUT == 5) exp_q.push_back(r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // External multiplier: result valid only in the last WAIT cycle, noise otherwise
  initial begin : mult_model
    int k;
    logic [31:0] pa, pb, prod;
    k = -1;
    pa = 0; pb = 0; prod = 0;
    bus.mult_res = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) k = -1;
      else if (bus.mult_load) begin
        k = 0; pa = bus.mult_a; pb = bus.mult_b; prod = ref_mm(pa, pb);
        load_cnt++;
      end else if (k >= 0 && k <= L) k++;
      if (k == L) begin
        bus.mult_res = prod;
        tests++;
        if (bus.mult_a !== pa || bus.mult_b !== pb) begin
          fails++;
          $display("FAIL operand_hold: got a=%h b=%h expected a=%h b=%h", bus.mult_a, bus.mult_b, pa, pb);
        end
      end else begin
        bus.mult_res = $urandom;
      end
    end
  end

  initial begin : sink
    int scnt;
    scnt = 0;
    bus.out_ready = 1'b0;
    forever begin
      tick();
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.out_valid && scnt < 7) begin
            bus.out_ready = 1'b0; scnt++;
          end else begin
            bus.out_ready = bus.out_valid; scnt = 0;
          end
        end
      endcase
    end
  end

  initial begin : monitor
    logic prev_stall, prev_valid;
    logic [7:0] prev_data;
    prev_stall = 0; prev_valid = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (prev_stall) begin
          tests++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
            fails++;
            $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", bus.out_valid, bus.out_data, prev_data);
          end
        end
        if (bus.out_valid === 1'b1) begin
          tests++;
          if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL in_ready_in_send: got %b expected 0", bus.in_ready);
          end
        end
        tests++;
        if (busy !== ~bus.in_ready) begin
          fails++;
          $display("FAIL busy: got %b expected %b", busy, ~bus.in_ready);
        end
        if (bus.out_valid && !prev_valid) first_valid_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
          rx_q.push_back(bus.out_data);
          last_rx_cyc = cyc;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_valid = bus.out_valid;
        prev_data  = bus.out_data;
      end else begin
        prev_stall = 0; prev_valid = 0;
      end
    end
  end

  task automatic send_frame(input logic [7:0] f[8], input int n, input bit keep_valid);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      bus.in_data  = f[i];
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && w < BOUND) begin tick(); w++; end
      tests++;
      if (w >= BOUND) begin
        fails++;
        $display("FAIL in_accept_timeout: got no in_ready after %0d cycles expected in_ready=1", w);
        bus.in_valid = 1'b0;
        return;
      end
      if (i == 0) acc0_cyc = cyc;
      if (i == 7) acc7_cyc = cyc;
      tick();
    end
    if (!keep_valid) bus.in_valid = 1'b0;
    if (n == 8) push_exp(f);
  endtask

  task automatic wait_out(input string name);
    int w;
    w = 0;
    while (rx_q.size() < exp_q.size() && w < BOUND) begin tick(); w++; end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d bytes expected %0d", name, rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (rx_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s_byte%0d: got %h expected %h", name, i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    reset = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    tests++;
    if (bus.out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h expected 00", bus.out_data); end
    tests++;
    if (bus.mult_load !== 1'b0) begin fails++; $display("FAIL rst_mult_load: got %b expected 0", bus.mult_load); end
    tests++;
    if (bus.mult_a !== 32'd0) begin fails++; $display("FAIL rst_mult_a: got %h expected 0", bus.mult_a); end
    tests++;
    if (bus.mult_b !== 32'd0) begin fails++; $display("FAIL rst_mult_b: got %h expected 0", bus.mult_b); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] f[8];
    int l0;
    ready_mode = 0;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        1: f = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08};
        default: f = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
      endcase
      l0 = load_cnt;
      send_frame(f, 8, 1'b0);
      wait_out($sformatf("directed%0d", t));
      tests++;
      if (load_cnt - l0 !== 1) begin
        fails++;
        $display("FAIL mult_load_cycles: got %0d expected 1", load_cnt - l0);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] f[8];
    f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    ready_mode = 2;
    send_frame(f, 8, 1'b0);
    wait_out("stall");
    ready_mode = 0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0] f[8];
    ready_mode = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) f[i] = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      send_frame(f, 8, 1'b0);
      wait_out("random");
    end
    ready_mode = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] f[8];
    int sz;
    f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    ready_mode = 0;
    send_frame(f, 5, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.mult_a !== 32'd0) begin
      fails++;
      $display("FAIL reset_collect: got in_ready=%b a=%h expected in_ready=1 a=0", bus.in_ready, bus.mult_a);
    end
    send_frame(f, 8, 1'b0);
    wait_out("after_partial");
    // drop a frame part-way through SEND
    ready_mode = 2;
    send_frame(f, 8, 1'b0);
    sz = 0;
    while (rx_q.size() < 1 && sz < BOUND) begin tick(); sz++; end
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sz = rx_q.size();
    repeat (40) tick();
    tests++;
    if (rx_q.size() != sz || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_send: got rx=%0d valid=%b in_ready=%b expected rx=%0d valid=0 in_ready=1",
               rx_q.size(), bus.out_valid, bus.in_ready, sz);
    end
    rx_q.delete();
    exp_q.delete();
    ready_mode = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[8];
    logic [7:0] f2[8];
    int a7, fv1, lr1, b0;
    for (int i = 0; i < 8; i++) begin f1[i] = 8'($urandom); f2[i] = 8'($urandom); end
    ready_mode = 0;
    tick();
    send_frame(f1, 8, 1'b1);
    a7 = acc7_cyc;
    send_frame(f2, 8, 1'b0);
    b0  = acc0_cyc;
    fv1 = first_valid_cyc;
    lr1 = last_rx_cyc;
    tests++;
    if (fv1 - a7 != L + 2) begin
      fails++;
      $display("FAIL latency: got %0d expected %0d", fv1 - a7, L + 2);
    end
    tests++;
    if (b0 != lr1 + 1) begin
      fails++;
      $display("FAIL no_bubble: got accept at %0d expected %0d", b0, lr1 + 1);
    end
    wait_out("b2b");
    tests++;
    if (first_valid_cyc - acc7_cyc != L + 2) begin
      fails++;
      $display("FAIL latency2: got %0d expected %0d", first_valid_cyc - acc7_cyc, L + 2);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
